mem_port_arbiter: RTL and testbench

//  Shares one single-port unified memory between the core's instruction-fetch (I) and load/store (D) requesters.

---
 rtl/mem_arb_pkg.sv | 26 ++
 rtl/mem_arb_prio.sv | 51 +++++
 rtl/mem_port_arbiter.sv | 209 ++++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the unified-memory port arbiter.
// Contents:
//   state_t  - arbiter FSM states (IDLE, ISSUE, WAIT, RESP)
//   owner_t  - current owner of the memory port (OWN_I fetch, OWN_D load/store)
//   *_DEF    - default parameter values used by mem_port_arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF   = 32;
  localparam int DATA_W_DEF   = 32;
  localparam int RD_LAT_DEF   = 1;
  localparam int MAX_WAIT_DEF = 4;
  localparam int STAT_W       = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/mem_arb_prio.sv
// Winner select for the memory port: fixed priority D over I, with a
// saturating count of consecutive arbitrations I has lost. Once the count
// reaches MAX_WAIT, I wins the next arbitration and the count clears.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   arb_en     arbitration allowed this cycle (FSM in IDLE)
//   i_req      fetch request
//   d_req      load/store request
//   grant_i    I wins this cycle (combinational)
//   grant_d    D wins this cycle (combinational)
module mem_arb_prio #(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic arb_en,
  input  logic i_req,
  input  logic d_req,
  output logic grant_i,
  output logic grant_d
);

  localparam int WAIT_W = $clog2(MAX_WAIT + 1);
  localparam logic [WAIT_W-1:0] WAIT_SAT = WAIT_W'(MAX_WAIT);

  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              starve;

  always_comb begin
    // Starvation only matters while I is actually asking; otherwise a
    // saturated count must not hold D off.
    starve     = i_req && (wait_cnt_q == WAIT_SAT);
    grant_d    = arb_en && d_req && !starve;
    grant_i    = arb_en && i_req && !grant_d;
    wait_cnt_d = wait_cnt_q;
    if (grant_i) begin
      wait_cnt_d = '0;
    end else if (grant_d && i_req && (wait_cnt_q != WAIT_SAT)) begin
      wait_cnt_d = wait_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt_q <= '0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch (I) and
// load/store (D). One access in flight; D has priority, I is protected
// from starvation by mem_arb_prio. Misaligned D accesses are answered with
// d_err without touching memory.
// Optional feature: define MEM_ARB_STATS_EN to add i_grant_cnt,
// d_grant_cnt and i_stall_cnt (32-bit, cleared by rst, wrapping).
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no access in flight; arbitrate and latch the winner's request
// ISSUE | mem_en high for one cycle with the latched address/data
// WAIT  | read latency beyond the first cycle (down-counter lat_cnt)
// RESP  | one-cycle ack to the owner; read data bypassed from mem_rdata
//
// Ports: clk, rst (sync, active-high); I side i_req/i_addr/i_ack/i_rdata;
// D side d_req/d_we/d_addr/d_wdata/d_ack/d_rdata/d_err; memory side
// mem_en/mem_we/mem_addr/mem_wdata/mem_rdata; busy (state != IDLE).
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W   = ADDR_W_DEF,
  parameter int DATA_W   = DATA_W_DEF,
  parameter int RD_LAT   = RD_LAT_DEF,
  parameter int MAX_WAIT = MAX_WAIT_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_ack,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_err,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
`ifdef MEM_ARB_STATS_EN
  ,
  output logic [STAT_W-1:0] i_grant_cnt,
  output logic [STAT_W-1:0] d_grant_cnt,
  output logic [STAT_W-1:0] i_stall_cnt
`endif
);

  localparam int LAT_W = $clog2(RD_LAT + 1);
  localparam bit HAS_WAIT = (RD_LAT > 1);
  // WAIT lasts RD_LAT-1 cycles: the counter runs RD_LAT-2 down to 0.
  localparam logic [LAT_W-1:0] LAT_LOAD = HAS_WAIT ? LAT_W'(RD_LAT - 2) : '0;

  state_t            state_q, state_d;
  owner_t            owner_q, owner_d;
  logic              we_q, we_d;
  logic              err_q, err_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [LAT_W-1:0]  lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] i_rdata_q, i_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;

  logic grant_i, grant_d;
  logic rd_resp;

  mem_arb_prio #(
    .MAX_WAIT(MAX_WAIT)
  ) u_prio (
    .clk    (clk),
    .rst    (rst),
    .arb_en (state_q == IDLE),
    .i_req  (i_req),
    .d_req  (d_req),
    .grant_i(grant_i),
    .grant_d(grant_d)
  );

  always_comb begin
    rd_resp   = (state_q == RESP) && !we_q && !err_q;
    i_ack     = (state_q == RESP) && (owner_q == OWN_I);
    d_ack     = (state_q == RESP) && (owner_q == OWN_D);
    d_err     = d_ack && err_q;
    mem_en    = (state_q == ISSUE);
    mem_we    = mem_en && we_q;
    mem_addr  = addr_q;
    mem_wdata = wdata_q;
    busy      = (state_q != IDLE);
    // Read data is live on mem_rdata in the RESP cycle; bypass it so the
    // data accompanies the ack, and hold the captured copy afterwards.
    i_rdata   = (rd_resp && owner_q == OWN_I) ? mem_rdata : i_rdata_q;
    d_rdata   = (rd_resp && owner_q == OWN_D) ? mem_rdata : d_rdata_q;
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    we_d      = we_q;
    err_d     = err_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    lat_cnt_d = lat_cnt_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    case (state_q)
      IDLE: begin
        if (grant_d) begin
          owner_d = OWN_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          if (d_addr[1:0] != 2'b00) begin
            err_d   = 1'b1;
            state_d = RESP;
          end else begin
            err_d   = 1'b0;
            state_d = ISSUE;
          end
        end else if (grant_i) begin
          owner_d = OWN_I;
          we_d    = 1'b0;
          err_d   = 1'b0;
          addr_d  = i_addr;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (HAS_WAIT && !we_q) begin
          lat_cnt_d = LAT_LOAD;
          state_d   = WAIT;
        end else begin
          state_d = RESP;
        end
      end
      WAIT: begin
        if (lat_cnt_q == '0) begin
          state_d = RESP;
        end else begin
          lat_cnt_d = lat_cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rd_resp && owner_q == OWN_I) i_rdata_d = mem_rdata;
        if (rd_resp && owner_q == OWN_D) d_rdata_d = mem_rdata;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      owner_q   <= OWN_I;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      lat_cnt_q <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      we_q      <= we_d;
      err_q     <= err_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      lat_cnt_q <= lat_cnt_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
    end
  end

`ifdef MEM_ARB_STATS_EN
  logic [STAT_W-1:0] i_grant_cnt_q, i_grant_cnt_d;
  logic [STAT_W-1:0] d_grant_cnt_q, d_grant_cnt_d;
  logic [STAT_W-1:0] i_stall_cnt_q, i_stall_cnt_d;
  logic              i_stalled;

  always_comb begin
    i_stalled     = i_req && !(busy && owner_q == OWN_I);
    i_grant_cnt_d = i_grant_cnt_q + {{(STAT_W-1){1'b0}}, grant_i};
    d_grant_cnt_d = d_grant_cnt_q + {{(STAT_W-1){1'b0}}, grant_d};
    i_stall_cnt_d = i_stall_cnt_q + {{(STAT_W-1){1'b0}}, i_stalled};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      i_grant_cnt_q <= '0;
      d_grant_cnt_q <= '0;
      i_stall_cnt_q <= '0;
    end else begin
      i_grant_cnt_q <= i_grant_cnt_d;
      d_grant_cnt_q <= d_grant_cnt_d;
      i_stall_cnt_q <= i_stall_cnt_d;
    end
  end

  assign i_grant_cnt = i_grant_cnt_q;
  assign d_grant_cnt = d_grant_cnt_q;
  assign i_stall_cnt = i_stall_cnt_q;
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter. Two instances: u_dut (RD_LAT=1)
// with a write-back memory model, u_dut3 (RD_LAT=3) with a fixed read
// pattern, used for mid-access reset and the WAIT path.
module tb_mem_port_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  // ---------------- instance with RD_LAT=1 ----------------
  logic        rst = 1'b1;
  logic        i_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
  logic [31:0] i_addr = '0, d_addr = '0, d_wdata = '0;
  logic        i_ack, d_ack, d_err, mem_en, mem_we, busy;
  logic [31:0] i_rdata, d_rdata, mem_addr, mem_wdata;
  logic [31:0] mem_rdata = '0;
`ifdef MEM_ARB_STATS_EN
  logic [31:0] i_grant_cnt, d_grant_cnt, i_stall_cnt;
  logic [31:0] i_grant_cnt3, d_grant_cnt3, i_stall_cnt3;
`endif

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(1), .MAX_WAIT(4)) u_dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ack(d_ack), .d_rdata(d_rdata), .d_err(d_err),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
`ifdef MEM_ARB_STATS_EN
    , .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt), .i_stall_cnt(i_stall_cnt)
`endif
  );

  logic [31:0] mem_arr [logic [31:0]];
  always @(posedge clk) begin
    if (mem_en && mem_we) mem_arr[mem_addr] = mem_wdata;
    if (mem_en && !mem_we)
      mem_rdata <= mem_arr.exists(mem_addr) ? mem_arr[mem_addr] : (mem_addr ^ 32'hA5A5A5A5);
  end

  // ---------------- instance with RD_LAT=3 ----------------
  logic        rst3 = 1'b1;
  logic        i_req3 = 1'b0;
  logic [31:0] i_addr3 = '0;
  logic        d_req3 = 1'b0, d_we3 = 1'b0;
  logic [31:0] d_addr3 = '0, d_wdata3 = '0;
  logic        i_ack3, d_ack3, d_err3, mem_en3, mem_we3, busy3;
  logic [31:0] i_rdata3, d_rdata3, mem_addr3, mem_wdata3;
  logic [31:0] p1 = '0, p2 = '0, p3 = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .RD_LAT(3), .MAX_WAIT(4)) u_dut3 (
    .clk(clk), .rst(rst3),
    .i_req(i_req3), .i_addr(i_addr3), .i_ack(i_ack3), .i_rdata(i_rdata3),
    .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
    .d_ack(d_ack3), .d_rdata(d_rdata3), .d_err(d_err3),
    .mem_en(mem_en3), .mem_we(mem_we3), .mem_addr(mem_addr3), .mem_wdata(mem_wdata3),
    .mem_rdata(p3), .busy(busy3)
`ifdef MEM_ARB_STATS_EN
    , .i_grant_cnt(i_grant_cnt3), .d_grant_cnt(d_grant_cnt3), .i_stall_cnt(i_stall_cnt3)
`endif
  );

  always @(posedge clk) begin
    p1 <= (mem_en3 && !mem_we3) ? (mem_addr3 ^ 32'hA5A5A5A5) : 32'h0;
    p2 <= p1;
    p3 <= p2;
  end

  // ---------------- tests (all activity on the falling edge) ----------------
  task automatic test_reset();
    rst = 1'b1; rst3 = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || busy3 !== 1'b0) begin errs++; $display("FAIL reset_busy: got %b/%b want 0/0", busy, busy3); end
    checks++; if (mem_en !== 1'b0 || mem_we !== 1'b0) begin errs++; $display("FAIL reset_mem_en: got en=%b we=%b want 0", mem_en, mem_we); end
    checks++; if (i_ack !== 1'b0 || d_ack !== 1'b0 || d_err !== 1'b0) begin errs++; $display("FAIL reset_ack: got %b %b %b want 0", i_ack, d_ack, d_err); end
    checks++; if (mem_addr !== 32'h0 || mem_wdata !== 32'h0) begin errs++; $display("FAIL reset_addr: got %h %h want 0", mem_addr, mem_wdata); end
    checks++; if (i_rdata !== 32'h0 || d_rdata !== 32'h0) begin errs++; $display("FAIL reset_rdata: got %h %h want 0", i_rdata, d_rdata); end
    rst = 1'b0; rst3 = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_i_read();
    i_req = 1'b1; i_addr = 32'h00400000;
    @(negedge clk); // issue cycle C
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h00400000) begin errs++; $display("FAIL iread_issue: got en=%b we=%b addr=%h want 1 0 00400000", mem_en, mem_we, mem_addr); end
    checks++; if (i_ack !== 1'b0 || busy !== 1'b1) begin errs++; $display("FAIL iread_issue_ack: got ack=%b busy=%b want 0 1", i_ack, busy); end
    @(negedge clk); // C+1
    checks++; if (i_ack !== 1'b1 || i_rdata !== 32'h00500093) begin errs++; $display("FAIL iread_ack: got ack=%b data=%h want 1 00500093", i_ack, i_rdata); end
    checks++; if (d_ack !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL iread_dack: got d_ack=%b en=%b want 0 0", d_ack, mem_en); end
    i_req = 1'b0;
    @(negedge clk);
    checks++; if (i_ack !== 1'b0 || busy !== 1'b0 || i_rdata !== 32'h00500093) begin errs++; $display("FAIL iread_hold: got ack=%b busy=%b data=%h want 0 0 00500093", i_ack, busy, i_rdata); end
  endtask

  task automatic test_d_store();
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h10; d_wdata = 32'hDEADBEEF;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h10 || mem_wdata !== 32'hDEADBEEF) begin errs++; $display("FAIL dstore_issue: got en=%b we=%b addr=%h wd=%h want 1 1 10 deadbeef", mem_en, mem_we, mem_addr, mem_wdata); end
    checks++; if (d_ack !== 1'b0) begin errs++; $display("FAIL dstore_early_ack: got %b want 0", d_ack); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || mem_en !== 1'b0) begin errs++; $display("FAIL dstore_ack: got ack=%b err=%b en=%b want 1 0 0", d_ack, d_err, mem_en); end
    d_req = 1'b0; d_we = 1'b0;
    @(negedge clk);
    checks++; if (d_ack !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL dstore_done: got ack=%b busy=%b want 0 0", d_ack, busy); end
  endtask

  task automatic test_d_load();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
    @(negedge clk);
    checks++; if (mem_en !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h10) begin errs++; $display("FAIL dload_issue: got en=%b we=%b addr=%h want 1 0 10", mem_en, mem_we, mem_addr); end
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_err !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL dload_ack: got ack=%b err=%b data=%h want 1 0 deadbeef", d_ack, d_err, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_misaligned();
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h12;
    @(negedge clk);
    checks++; if (d_ack !== 1'b1 || d_err !== 1'b1) begin errs++; $display("FAIL misalign_ack: got ack=%b err=%b want 1 1", d_ack, d_err); end
    checks++; if (mem_en !== 1'b0 || d_rdata !== 32'hDEADBEEF) begin errs++; $display("FAIL misalign_mem: got en=%b data=%h want 0 deadbeef", mem_en, d_rdata); end
    d_req = 1'b0;
    @(negedge clk);
    checks++; if (mem_en !== 1'b0 || d_ack !== 1'b0 || d_err !== 1'b0 || busy !== 1'b0) begin errs++; $display("FAIL misalign_after: got en=%b ack=%b err=%b busy=%b want 0", mem_en, d_ack, d_err, busy); end
  endtask

  task automatic test_priority();
    bit [9:0] exp_seq = 10'b10000_10000; // bit k = 1 when grant k goes to I
    bit [9:0] got_seq = '0;
    int grants = 0, i_acks = 0, d_acks = 0, extra = 0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    i_req = 1'b1; i_addr = 32'h00400000;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
    for (int cyc = 0; cyc < 200 && (i_acks + d_acks) < 10; cyc++) begin
      @(negedge clk);
      if (mem_en) begin
        if (grants < 10) got_seq[grants] = (mem_addr == 32'h00400000);
        grants++;
      end
      if (i_ack) i_acks++;
      if (d_ack) d_acks++;
      if ((i_acks + d_acks) >= 10) begin i_req = 1'b0; d_req = 1'b0; end
    end
    i_req = 1'b0; d_req = 1'b0;
    checks++; if ((i_acks + d_acks) != 10) begin errs++; $display("FAIL prio_timeout: got %0d acks want 10", i_acks + d_acks); end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (got_seq[k] !== exp_seq[k]) begin errs++; $display("FAIL prio_grant%0d: got owner_i=%b want %b", k, got_seq[k], exp_seq[k]); end
    end
    checks++; if (i_acks != 2 || d_acks != 8) begin errs++; $display("FAIL prio_acks: got i=%0d d=%0d want 2 8", i_acks, d_acks); end
    repeat (4) begin
      @(negedge clk);
      if (mem_en || i_ack || d_ack) extra++;
    end
    checks++; if (extra != 0 || grants != 10) begin errs++; $display("FAIL prio_extra: got grants=%0d extra=%0d want 10 0", grants, extra); end
`ifdef MEM_ARB_STATS_EN
    checks++; if (d_grant_cnt !== 32'd8 || i_grant_cnt !== 32'd2) begin errs++; $display("FAIL stats_grants: got d=%0d i=%0d want 8 2", d_grant_cnt, i_grant_cnt); end
    checks++; if (i_stall_cnt !== 32'd26) begin errs++; $display("FAIL stats_stall: got %0d want 26", i_stall_cnt); end
`endif
  endtask

  task automatic test_reset_inflight();
    int stray = 0;
    i_req3 = 1'b1; i_addr3 = 32'h100;
    @(negedge clk); // C
    checks++; if (mem_en3 !== 1'b1 || mem_addr3 !== 32'h100) begin errs++; $display("FAIL rst3_issue: got en=%b addr=%h want 1 100", mem_en3, mem_addr3); end
    @(negedge clk); // C+1
    checks++; if (busy3 !== 1'b1) begin errs++; $display("FAIL rst3_wait_busy: got %b want 1", busy3); end
    rst3 = 1'b1; i_req3 = 1'b0;
    @(negedge clk); // C+2
    rst3 = 1'b0;
    checks++; if (busy3 !== 1'b0 || i_ack3 !== 1'b0) begin errs++; $display("FAIL rst3_abandon: got busy=%b ack=%b want 0 0", busy3, i_ack3); end
    repeat (4) begin
      @(negedge clk);
      if (i_ack3 || busy3) stray++;
    end
    checks++; if (stray != 0) begin errs++; $display("FAIL rst3_no_ack: got %0d stray cycles want 0", stray); end
    i_req3 = 1'b1; i_addr3 = 32'h200;
    @(negedge clk); // C
    checks++; if (mem_en3 !== 1'b1 || mem_addr3 !== 32'h200) begin errs++; $display("FAIL rd3_issue: got en=%b addr=%h want 1 200", mem_en3, mem_addr3); end
    @(negedge clk); // C+1
    checks++; if (i_ack3 !== 1'b0 || busy3 !== 1'b1) begin errs++; $display("FAIL rd3_wait1: got ack=%b busy=%b want 0 1", i_ack3, busy3); end
    @(negedge clk); // C+2
    checks++; if (i_ack3 !== 1'b0 || busy3 !== 1'b1) begin errs++; $display("FAIL rd3_wait2: got ack=%b busy=%b want 0 1", i_ack3, busy3); end
    @(negedge clk); // C+3
    checks++; if (i_ack3 !== 1'b1 || i_rdata3 !== (32'h200 ^ 32'hA5A5A5A5)) begin errs++; $display("FAIL rd3_ack: got ack=%b data=%h want 1 %h", i_ack3, i_rdata3, 32'h200 ^ 32'hA5A5A5A5); end
    i_req3 = 1'b0;
    @(negedge clk);
    checks++; if (i_ack3 !== 1'b0 || busy3 !== 1'b0 || i_rdata3 !== (32'h200 ^ 32'hA5A5A5A5)) begin errs++; $display("FAIL rd3_hold: got ack=%b busy=%b data=%h", i_ack3, busy3, i_rdata3); end
  endtask

  initial begin
    mem_arr[32'h00400000] = 32'h00500093;
    test_reset();
    test_i_read();
    test_d_store();
    test_d_load();
    test_misaligned();
    test_priority();
    test_reset_inflight();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
